frame_payload_packer: RTL and testbench
=======================================

// Module: frame_payload_packer
// PURPOSE
// Downstream stage of the frame aligner. Consumes rx_data, frame_detect and fr_byte_position.
// Strips the header and buffers payload bytes of aligned frames in a commit/rollback FIFO.
// Delivers only complete frames on a valid/ready byte stream with SOF/EOF markers.
// Partial frames (alignment lost mid-frame) and frames that do not fit are discarded and counted.
// PARAMETERS
// FRAME_LEN   12  total bytes per frame, header included (positions 0..FRAME_LEN-1)
// HDR_LEN     2   header bytes at positions 0..HDR_LEN-1; payload is positions HDR_LEN..FRAME_LEN-1
// FIFO_DEPTH  32  payload FIFO entries; power of 2, >= FRAME_LEN-HDR_LEN
// CNT_W       16  width of statistics counters
// PORTS
// clk               in   1      clock; all logic on posedge
// reset             in   1      synchronous, active-high reset
// rx_data           in   8      byte from aligner, one per clk
// frame_detect      in   1      aligner locked; fr_byte_position valid only while 1
// fr_byte_position  in   4      position of rx_data within current frame
// out_data          out  8      payload byte at FIFO head
// out_sof           out  1      out_data is first payload byte of a frame
// out_eof           out  1      out_data is last payload byte of a frame
// out_valid         out  1      out_data/sof/eof valid
// out_ready         in   1      consumer accepts byte when out_valid & out_ready
// frame_cnt         out  CNT_W  frames committed (saturating)
// drop_cnt          out  CNT_W  frames dropped for lack of space (saturating)
// abort_cnt         out  CNT_W  frames aborted mid-capture (saturating)
// BEHAVIOUR
// Reset: out_valid=0, out_sof=0, out_eof=0, out_data=0, all counters=0, all pointers=0, FSM=IDLE.
// Pointers: rd_ptr, wr_ptr, cmt_ptr, each $clog2(FIFO_DEPTH)+1 bits, wrap naturally.
// out_valid = (rd_ptr != cmt_ptr). Only committed bytes are ever visible.
// Each entry stores {sof,eof,data[7:0]}.
// FSM states: IDLE, CAPTURE, DROP. exp_pos is the internal expected position.
//  IDLE: frame_detect=1 and pos==HDR_LEN
//   - free = FIFO_DEPTH-(wr_ptr-rd_ptr); the space check uses rd_ptr as of this cycle.
//   - free >= PLEN (PLEN=FRAME_LEN-HDR_LEN): write byte with sof=1; CAPTURE, exp_pos=HDR_LEN+1.
//   - else: drop_cnt++, go to DROP.
//  CAPTURE: frame_detect=1 and pos==exp_pos -> write byte, exp_pos++.
//   - On pos==FRAME_LEN-1, write with eof=1 and set cmt_ptr<=wr_ptr+1 on the same edge.
//   - Then frame_cnt++ and go to IDLE.
//  CAPTURE abort: frame_detect=0 or pos!=exp_pos -> wr_ptr<=cmt_ptr (rollback), abort_cnt++, go to IDLE.
//   - The offending byte is not written.
//   - If it is frame_detect=1 & pos==HDR_LEN, it is not reconsidered until the next frame.
//  DROP: stay until pos==FRAME_LEN-1 or frame_detect=0, then go to IDLE; nothing written.
// Latency: first byte of a frame has out_valid=1 the cycle after its last payload byte (pos FRAME_LEN-1) is sampled.
// Read side: out_valid & out_ready -> rd_ptr++ at the edge.
//  - Reads and writes/commits in the same cycle are both honoured.
//  - The freed entry is not counted as space until the next cycle.
// Full: the admission check guarantees writes never overflow. Empty: out_valid=0, out_data is don't-care.
// Counters saturate at all-ones and do not wrap.
// Reset mid-operation discards committed and uncommitted data alike; no partial frame is ever emitted.
// frame_detect=0 in IDLE: ignored, nothing is written.
// TESTING
// 1. Assert reset 3 cycles -> out_valid=0, frame_cnt=drop_cnt=abort_cnt=0.
// 2. Frame, pos 0..11, payload 0x01..0x0A, out_ready=1:
//    - out_data 0x01..0x0A on 10 consecutive cycles, starting the cycle after pos 11.
//    - sof with 0x01, eof with 0x0A; frame_cnt=1.
// 3. out_ready=0, 4 back-to-back frames (DEPTH=32):
//    - frames 1-3 committed (30 bytes); 4th dropped -> drop_cnt=1.
//    - Then out_ready=1 -> exactly 30 bytes, 3 sof, 3 eof.
// 4. frame_detect drops at pos 6 -> no output, abort_cnt=1. Next clean frame output intact, frame_cnt=1.
// 5. pos sequence ..5,7.. while frame_detect=1 -> abort_cnt=1, no bytes of that frame appear.
// 6. 2 committed frames pending, then reset mid-capture of a 3rd -> out_valid=0 the next cycle, counters=0.
//    - After reset, a new frame outputs normally.

Source files
------------

// File: rtl/frame_payload_packer_if.sv
// rtl/frame_payload_packer_if.sv - payload byte stream between packer and consumer
interface frame_payload_packer_if;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_sof,
    output out_eof,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_sof,
    input  out_eof,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/frame_payload_packer.sv
// rtl/frame_payload_packer.sv - strips frame headers and releases whole payloads from a commit/rollback FIFO
module frame_payload_packer #(
  parameter int FRAME_LEN  = 12,
  parameter int HDR_LEN    = 2,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   frame_detect,
  input  logic [3:0]             fr_byte_position,
  frame_payload_packer_if.master out,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       abort_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_V = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] PLEN_V  = (PW+1)'(FRAME_LEN - HDR_LEN);
  localparam logic [3:0]  POS_HDR  = 4'(HDR_LEN);
  localparam logic [3:0]  POS_NEXT = 4'(HDR_LEN + 1);
  localparam logic [3:0]  POS_LAST = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DROP} state_t;

  state_t        state;
  logic [3:0]    exp_pos;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] cmt_ptr;
  logic [9:0]    mem [FIFO_DEPTH];

  logic [PW-1:0] used;
  logic [PW:0]   free;
  logic          hdr_ok;
  logic          in_seq;
  logic          is_last;
  logic          fits;
  logic          wr_en;
  logic [9:0]    wr_word;
  logic          rd_fire;
  logic [9:0]    head;

  // Space is judged against the registered rd_ptr, so a byte read this cycle frees nothing yet.
  assign used    = wr_ptr - rd_ptr;
  assign free    = DEPTH_V - {1'b0, used};
  assign fits    = (free >= PLEN_V);
  assign hdr_ok  = frame_detect && (fr_byte_position == POS_HDR);
  assign in_seq  = frame_detect && (fr_byte_position == exp_pos);
  assign is_last = (fr_byte_position == POS_LAST);

  always_comb begin
    wr_en   = 1'b0;
    wr_word = {2'b00, rx_data};
    case (state)
      IDLE: begin
        if (hdr_ok && fits) begin
          wr_en   = 1'b1;
          wr_word = {1'b1, 1'b0, rx_data};
        end
      end
      CAPTURE: begin
        if (in_seq) begin
          wr_en   = 1'b1;
          wr_word = {1'b0, is_last, rx_data};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_word;
    end
  end

  // Only bytes behind cmt_ptr are visible, so a rolled-back frame never leaks out.
  assign head          = mem[rd_ptr[AW-1:0]];
  assign out.out_valid = (rd_ptr != cmt_ptr);
  assign out.out_data  = out.out_valid ? head[7:0] : 8'h00;
  assign out.out_sof   = out.out_valid & head[9];
  assign out.out_eof   = out.out_valid & head[8];
  assign rd_fire       = out.out_valid & out.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      exp_pos   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cmt_ptr   <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      abort_cnt <= '0;
    end else begin
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case (state)
        IDLE: begin
          if (hdr_ok) begin
            if (fits) begin
              wr_ptr  <= wr_ptr + 1'b1;
              exp_pos <= POS_NEXT;
              state   <= CAPTURE;
            end else begin
              if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
              state <= DROP;
            end
          end
        end
        CAPTURE: begin
          if (in_seq) begin
            wr_ptr  <= wr_ptr + 1'b1;
            exp_pos <= exp_pos + 1'b1;
            if (is_last) begin
              cmt_ptr <= wr_ptr + 1'b1;
              if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
              state <= IDLE;
            end
          end else begin
            wr_ptr <= cmt_ptr;
            if (abort_cnt != '1) abort_cnt <= abort_cnt + 1'b1;
            state <= IDLE;
          end
        end
        DROP: begin
          if (!frame_detect || is_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_payload_packer.sv
// tb/tb_frame_payload_packer.sv - directed self-checking bench for frame_payload_packer
module tb_frame_payload_packer;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        frame_detect;
  logic [3:0]  fr_byte_position;
  logic [15:0] frame_cnt, drop_cnt, abort_cnt;

  frame_payload_packer_if bus ();

  frame_payload_packer dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .frame_detect     (frame_detect),
    .fr_byte_position (fr_byte_position),
    .out              (bus),
    .frame_cnt        (frame_cnt),
    .drop_cnt         (drop_cnt),
    .abort_cnt        (abort_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;
  logic [9:0] got[$];
  logic [9:0] exp_q[$];

  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready)
      got.push_back({bus.out_sof, bus.out_eof, bus.out_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fd, input int pos, input logic [7:0] d);
    frame_detect     = fd;
    fr_byte_position = 4'(pos);
    rx_data          = d;
    tick();
  endtask

  task automatic idle(input int n);
    frame_detect = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input logic [7:0] base, input int first, input int last);
    for (int p = first; p <= last; p++)
      drive(1'b1, p, (p < 2) ? 8'(8'hF0 + p) : 8'(base + p - 2));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_detect = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] base);
    for (int j = 0; j < 10; j++)
      exp_q.push_back({(j == 0), (j == 9), 8'(base + j)});
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {22'd0, got[i]}, {22'd0, exp_q[i]});
    got.delete();
    exp_q.delete();
  endtask

  // Called right after the edge that sampled the last payload byte; checks latency and order.
  task automatic check_frame(input string tag, input logic [7:0] base);
    frame_detect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), bus.out_valid, 1'b1);
      chk($sformatf("%s_data%0d", tag, i), bus.out_data, 8'(base + i));
      chk($sformatf("%s_sof%0d", tag, i), bus.out_sof, (i == 0));
      chk($sformatf("%s_eof%0d", tag, i), bus.out_eof, (i == 9));
      tick();
    end
    chk({tag, "_empty"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    rx_data = 8'h00;
    frame_detect = 1'b0;
    fr_byte_position = 4'd0;
    bus.out_ready = 1'b0;

    // 1: reset state
    do_reset();
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_sof", bus.out_sof, 1'b0);
    chk("rst_eof", bus.out_eof, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_drop_cnt", drop_cnt, 16'd0);
    chk("rst_abort_cnt", abort_cnt, 16'd0);

    // 2: single frame, payload 0x01..0x0A, always ready
    bus.out_ready = 1'b1;
    send_frame(8'h01, 0, 10);
    chk("t2_not_early", bus.out_valid, 1'b0);
    send_frame(8'h01, 11, 11);
    check_frame("t2", 8'h01);
    chk("t2_frame_cnt", frame_cnt, 16'd1);

    // 3: four back-to-back frames with consumer stalled; fourth does not fit
    do_reset();
    bus.out_ready = 1'b0;
    mon_en = 1'b1;
    send_frame(8'h10, 0, 11);
    send_frame(8'h20, 0, 11);
    send_frame(8'h30, 0, 11);
    send_frame(8'h40, 0, 11);
    idle(1);
    chk("t3_frame_cnt", frame_cnt, 16'd3);
    chk("t3_drop_cnt", drop_cnt, 16'd1);
    chk("t3_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    idle(40);
    expect_frame(8'h10);
    expect_frame(8'h20);
    expect_frame(8'h30);
    compare_stream("t3");
    chk("t3_empty", bus.out_valid, 1'b0);

    // 4: frame_detect lost at position 6, then a clean frame
    do_reset();
    send_frame(8'h50, 0, 5);
    drive(1'b0, 6, 8'h55);
    idle(4);
    chk("t4_no_out", bus.out_valid, 1'b0);
    chk("t4_abort_cnt", abort_cnt, 16'd1);
    chk("t4_got_none", got.size(), 0);
    send_frame(8'h60, 0, 11);
    check_frame("t4", 8'h60);
    chk("t4_frame_cnt", frame_cnt, 16'd1);
    got.delete();

    // 5: position skips 6 while locked
    do_reset();
    send_frame(8'h70, 0, 5);
    send_frame(8'h70, 7, 11);
    idle(4);
    chk("t5_abort_cnt", abort_cnt, 16'd1);
    chk("t5_frame_cnt", frame_cnt, 16'd0);
    chk("t5_no_out", bus.out_valid, 1'b0);
    chk("t5_got_none", got.size(), 0);
    mon_en = 1'b0;

    // 6: reset while two frames pending and a third in capture
    do_reset();
    bus.out_ready = 1'b0;
    send_frame(8'h11, 0, 11);
    send_frame(8'h21, 0, 11);
    send_frame(8'h31, 0, 5);
    chk("t6_pending", bus.out_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", bus.out_valid, 1'b0);
    chk("t6_frame_cnt", frame_cnt, 16'd0);
    chk("t6_drop_cnt", drop_cnt, 16'd0);
    chk("t6_abort_cnt", abort_cnt, 16'd0);
    idle(2);
    chk("t6_still_empty", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    send_frame(8'h41, 0, 11);
    check_frame("t6", 8'h41);

    // 7: reads overlap capture of the next frame
    do_reset();
    got.delete();
    mon_en = 1'b1;
    bus.out_ready = 1'b1;
    send_frame(8'h90, 0, 11);
    send_frame(8'hA0, 0, 11);
    idle(15);
    expect_frame(8'h90);
    expect_frame(8'hA0);
    compare_stream("t7");
    chk("t7_frame_cnt", frame_cnt, 16'd2);

    // 8: exact-fit admission (free == 10), then FIFO completely full
    do_reset();
    bus.out_ready = 1'b0;
    send_frame(8'h10, 0, 11);
    send_frame(8'h20, 0, 11);
    send_frame(8'h30, 0, 11);
    frame_detect = 1'b0;
    bus.out_ready = 1'b1;
    idle(8);
    bus.out_ready = 1'b0;
    send_frame(8'hB0, 0, 11);
    chk("t8_fit_frame_cnt", frame_cnt, 16'd4);
    chk("t8_fit_drop_cnt", drop_cnt, 16'd0);
    send_frame(8'hC0, 0, 11);
    chk("t8_full_drop_cnt", drop_cnt, 16'd1);
    chk("t8_full_frame_cnt", frame_cnt, 16'd4);
    bus.out_ready = 1'b1;
    idle(50);
    expect_frame(8'h10);
    expect_frame(8'h20);
    expect_frame(8'h30);
    expect_frame(8'hB0);
    compare_stream("t8");
    chk("t8_empty", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
